// File: rtl/poly_normalize_pkg.sv
// Shared types and constants for the polynomial normalizer.
package poly_normalize_pkg;

    localparam int NumCoeffs = 4;
    localparam int WordBits  = 16;
    localparam int CoeffBits = 17;

    // Carry headroom, canonical value width and accumulator width
    localparam int CW = CoeffBits - WordBits + 1;
    localparam int VW = NumCoeffs * WordBits;
    localparam int AW = VW + CW;

    // 2^64 - 59
    localparam logic [VW-1:0] Modulus = 64'hFFFF_FFFF_FFFF_FFC5;

    // Coefficient i carries weight 2^(i*WordBits)
    typedef logic [NumCoeffs-1:0][CoeffBits-1:0] poly_t;

    typedef enum logic [1:0] {IDLE, CARRY, REDUCE, DONE} norm_state_t;

endpackage

// File: rtl/poly_normalize_if.sv
// Input/output handshake bundle for poly_normalize.
interface poly_normalize_if;
    import poly_normalize_pkg::*;

    logic            valid_i;
    logic            ready_o;
    poly_t           poly_i;
    logic            valid_o;
    logic            ready_i;
    logic [VW-1:0]   value_o;
    logic            err_o;

    modport slave  (input  valid_i, poly_i, ready_i,
                    output ready_o, valid_o, value_o, err_o);
    modport master (output valid_i, poly_i, ready_i,
                    input  ready_o, valid_o, value_o, err_o);
endinterface

// File: rtl/poly_normalize_cond_sub.sv
// Compare-and-subtract of the accumulator against the modulus, kept
// separate so the wide compare/subtract path is its own timing island.
module cond_sub
    import poly_normalize_pkg::*;
(
    input  logic [AW-1:0] acc_i,
    input  logic [AW-1:0] mod_i,
    output logic          ge_o,
    output logic [AW-1:0] diff_o
);
    assign ge_o   = (acc_i >= mod_i);
    assign diff_o = acc_i - mod_i;
endmodule

// File: rtl/poly_normalize.sv
// Redundant polynomial -> canonical integer in [0, Modulus): one carry
// step per coefficient, then up to MAX_SUB conditional subtractions.
module poly_normalize
    import poly_normalize_pkg::*;
#(
    parameter int MAX_SUB = 3
) (
    input logic             clk,
    input logic             rst_n,
    poly_normalize_if.slave bus
);
    localparam int IW  = (NumCoeffs > 1) ? $clog2(NumCoeffs) : 1;
    localparam int SCW = (MAX_SUB > 0) ? $clog2(MAX_SUB + 1) : 1;
    localparam int SW  = CoeffBits + 1;

    norm_state_t      state_q, state_d;
    poly_t            poly_q, poly_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    carry_q, carry_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [SCW-1:0]   sub_q, sub_d;
    logic             err_q, err_d;

    logic [SW-1:0]    sum;
    logic             ge;
    logic [AW-1:0]    diff;

    // One carry-propagation step on the currently indexed coefficient
    assign sum = SW'(poly_q[idx_q]) + SW'(carry_q);

    cond_sub u_cond_sub (
        .acc_i  (acc_q),
        .mod_i  (AW'(Modulus)),
        .ge_o   (ge),
        .diff_o (diff)
    );

    // Outputs depend on registered state only
    assign bus.ready_o = (state_q == IDLE);
    assign bus.valid_o = (state_q == DONE);
    assign bus.value_o = acc_q[VW-1:0];
    assign bus.err_o   = err_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            poly_q  <= '0;
            idx_q   <= '0;
            carry_q <= '0;
            acc_q   <= '0;
            sub_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            poly_q  <= poly_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            sub_q   <= sub_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        poly_d  = poly_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        sub_d   = sub_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
                    poly_d  = bus.poly_i;
                    idx_d   = '0;
                    carry_d = '0;
                    sub_d   = '0;
                    // Clear stale result so nothing leaks into the next one
                    acc_d   = '0;
                    err_d   = 1'b0;
                    state_d = CARRY;
                end
            end
            CARRY: begin
                acc_d[idx_q*WordBits +: WordBits] = sum[WordBits-1:0];
                carry_d = sum[SW-1:WordBits];
                idx_d   = idx_q + IW'(1);
                if (idx_q == IW'(NumCoeffs - 1)) begin
                    // Final carry lands in the headroom above the value
                    acc_d[AW-1 -: CW] = sum[SW-1:WordBits];
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                if (!ge) begin
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (sub_q < SCW'(MAX_SUB)) begin
                    acc_d = diff;
                    sub_d = sub_q + SCW'(1);
                end else begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_poly_normalize.sv
// Randomized bench for poly_normalize with a value-level reference model.
module tb_poly_normalize;
    import poly_normalize_pkg::*;

    typedef struct {
        logic [VW-1:0] val;
        bit            err;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   bp_mode = 2;   // 0 random ready_i, 1 held low, 2 held high
    exp_t q[$];
    logic [VW-1:0] last_val;
    bit   last_err;

    poly_normalize_if ifc ();
    poly_normalize_if ifc2 ();

    poly_normalize #(.MAX_SUB(3)) dut  (.clk(clk), .rst_n(rst_n), .bus(ifc));
    poly_normalize #(.MAX_SUB(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc2));

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input bit ok, input string nm,
                       input logic [127:0] got, input logic [127:0] want);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Integer value of the redundant form, then subtract the modulus while
    // it is still too large and the budget allows
    function automatic void model(input poly_t p, input int maxs,
                                  output logic [VW-1:0] val, output bit err,
                                  output int s);
        logic [AW+7:0] v;
        v = '0;
        for (int i = 0; i < NumCoeffs; i++)
            v = v + ((AW+8)'(p[i]) << (WordBits * i));
        s = 0;
        while (v >= (AW+8)'(Modulus) && s < maxs) begin
            v = v - (AW+8)'(Modulus);
            s++;
        end
        err = (v >= (AW+8)'(Modulus));
        val = v[VW-1:0];
    endfunction

    function automatic poly_t mk(input logic [16:0] c3, c2, c1, c0);
        poly_t p;
        p[3] = c3; p[2] = c2; p[1] = c1; p[0] = c0;
        return p;
    endfunction

    // Offer one input, record its expected result once it is accepted
    task automatic send(input poly_t p);
        int w;
        exp_t e;
        int s;
        @(posedge clk); #1;
        ifc.valid_i = 1'b1;
        ifc.poly_i  = p;
        w = 0;
        while (!ifc.ready_o && w < 60) begin
            @(posedge clk); #1;
            w++;
        end
        chk(ifc.ready_o, "accept_timeout", ifc.ready_o, 1);
        if (ifc.ready_o) begin
            model(p, 3, e.val, e.err, s);
            e.due = cyc + NumCoeffs + s + 2;
            q.push_back(e);
        end
        @(posedge clk); #1;
        ifc.valid_i = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        chk(q.size() == 0, "drain_timeout", q.size(), 0);
    endtask

    // Consumer backpressure pattern
    initial begin
        ifc.ready_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            ifc.ready_i = (bp_mode == 0) ? ($urandom_range(0, 2) != 0) : (bp_mode == 2);
        end
    end

    // Compare process: every cycle a result is presented
    initial begin
        bit prev_v, prev_hs;
        prev_v = 0;
        prev_hs = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 0;
                prev_hs = 0;
            end else begin
                if (prev_hs)
                    chk(ifc.ready_o && !ifc.valid_o, "ready_after_ack",
                        {ifc.ready_o, ifc.valid_o}, 2'b10);
                if (prev_v)
                    chk(ifc.valid_o, "valid_held", ifc.valid_o, 1);
                if (ifc.valid_o) begin
                    chk(q.size() != 0, "unexpected_valid", q.size(), 1);
                    if (q.size() != 0) begin
                        if (!prev_v) chk(cyc == q[0].due, "latency", cyc, q[0].due);
                        chk(ifc.value_o == q[0].val, "value", ifc.value_o, q[0].val);
                        chk(ifc.err_o == q[0].err, "err", ifc.err_o, q[0].err);
                        chk(!ifc.ready_o, "ready_low_busy", ifc.ready_o, 0);
                        if (ifc.ready_i) begin
                            last_val = ifc.value_o;
                            last_err = ifc.err_o;
                            void'(q.pop_front());
                        end
                    end
                end
                prev_v  = ifc.valid_o && !ifc.ready_i;
                prev_hs = ifc.valid_o && ifc.ready_i;
            end
        end
    end

    initial begin
        logic [VW-1:0] mv;
        bit            me;
        int            ms;
        int            k;
        poly_t         p;
        poly_t         dir_p[5];
        logic [VW-1:0] dir_v[5];

        ifc.valid_i  = 1'b0;
        ifc.poly_i   = '0;
        ifc2.valid_i = 1'b0;
        ifc2.poly_i  = '0;
        ifc2.ready_i = 1'b1;

        // Reset state
        #12;
        chk(ifc.ready_o == 1'b1, "rst_ready", ifc.ready_o, 1);
        chk(ifc.valid_o == 1'b0, "rst_valid", ifc.valid_o, 0);
        chk(ifc.value_o == '0, "rst_value", ifc.value_o, 0);
        chk(ifc.err_o == 1'b0, "rst_err", ifc.err_o, 0);
        chk(ifc2.ready_o == 1'b1 && ifc2.valid_o == 1'b0, "rst_dut1",
            {ifc2.ready_o, ifc2.valid_o}, 2'b10);

        // Pin the model with hand-computed results
        model(mk(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF), 3, mv, me, ms);
        chk(mv == 64'h0001_0001_0001_0075 && !me && ms == 2, "model_two_sub", mv, 64'h0001_0001_0001_0075);
        model(mk(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF), 1, mv, me, ms);
        chk(mv == 64'h0001_0001_0001_003A && me, "model_exhaust", mv, 64'h0001_0001_0001_003A);
        model(mk(0, 0, 0, 17'h1FFFF), 3, mv, me, ms);
        chk(mv == 64'h0000_0000_0001_FFFF && ms == 0, "model_carry", mv, 64'h1FFFF);

        @(posedge clk); #1;
        rst_n = 1'b1;

        // MAX_SUB=1 instance: exhaustion flags err and latency T+7
        ifc2.valid_i = 1'b1;
        ifc2.poly_i  = mk(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF);
        @(posedge clk); #1;
        ifc2.valid_i = 1'b0;
        k = 1;
        while (!ifc2.valid_o && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        chk(k == 7, "dut1_latency", k, 7);
        chk(ifc2.value_o == 64'h0001_0001_0001_003A, "dut1_value", ifc2.value_o, 64'h0001_0001_0001_003A);
        chk(ifc2.err_o == 1'b1, "dut1_err", ifc2.err_o, 1);

        // Directed cases with literal final values
        dir_p[0] = mk(5, 0, 0, 0);                                   dir_v[0] = 64'h0005_0000_0000_0000;
        dir_p[1] = mk(0, 0, 0, 17'h1FFFF);                           dir_v[1] = 64'h0000_0000_0001_FFFF;
        dir_p[2] = mk(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF);   dir_v[2] = 64'h0001_0001_0001_0075;
        dir_p[3] = mk(17'hFFFF, 17'hFFFF, 17'hFFFF, 17'hFFC5);       dir_v[3] = 64'h0;
        dir_p[4] = mk(17'hFFFF, 17'hFFFF, 17'hFFFF, 17'hFFC4);       dir_v[4] = 64'hFFFF_FFFF_FFFF_FFC4;
        for (int i = 0; i < 5; i++) begin
            send(dir_p[i]);
            drain();
            chk(last_val == dir_v[i] && !last_err, "directed_value", last_val, dir_v[i]);
        end

        // Backpressure: result held for 10 cycles, then a second input
        bp_mode = 1;
        send(mk(0, 0, 17'h1ABCD, 17'h10001));
        k = 0;
        while (!ifc.valid_o && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (10) @(posedge clk);
        bp_mode = 2;
        drain();
        send(mk(5, 0, 0, 0));
        drain();
        chk(last_val == 64'h0005_0000_0000_0000, "after_bp_value", last_val, 64'h0005_0000_0000_0000);

        // Reset while the carry step is at index 2
        send(mk(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk(ifc.ready_o == 1'b1, "midrst_ready", ifc.ready_o, 1);
        chk(ifc.valid_o == 1'b0, "midrst_valid", ifc.valid_o, 0);
        chk(ifc.value_o == '0 && ifc.err_o == 1'b0, "midrst_value", ifc.value_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(mk(5, 0, 0, 0));
        drain();
        chk(last_val == 64'h0005_0000_0000_0000 && !last_err, "post_rst_value",
            last_val, 64'h0005_0000_0000_0000);

        // Randomized traffic with random backpressure
        bp_mode = 0;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NumCoeffs; i++) begin
                case ($urandom_range(0, 3))
                    0:       p[i] = 17'h1FFFF;
                    1:       p[i] = 17'h0FFFF;
                    default: p[i] = 17'($urandom_range(0, 32'h1FFFF));
                endcase
            end
            send(p);
        end
        drain();
        bp_mode = 2;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
